// File: rtl/led_panel_scan_ctrl.sv
// -----------------------------------------------------------------------------
// led_panel_scan_ctrl
//
// Scan controller for a HUB-style LED panel. For every row and every BCM
// bit-plane it fetches COLS pixel pairs from a pixel source, shifts them out
// on a single time-multiplexed colour lane (lower half while sclk is low,
// upper half while sclk is high), latches the row, unblanks the panel for
// BASE_HOLD<<plane cycles and then advances plane / row address.
//
// Ports
//   clk, reset                 system clock, asynchronous active-high reset
//   rowmax_in[3:0]             index of the last panel row
//   pix_req / pix_ack          pixel fetch handshake
//   pix_col/pix_row/pix_plane  coordinates of the pixel being requested
//   pix_lo_rgb / pix_hi_rgb    {r,g,b} for lower / upper panel half
//   red_out/green_out/blue_out panel colour data
//   sclk_out, latch_out        column shift clock, latch pulse
//   blank_out                  panel blanking (high = dark)
//   aclk_out, arst_out         row address advance / reset pulses
//   frame_out                  one-cycle end-of-frame pulse
//   dbg_state_out[2:0]         current FSM state, for observation only
//
// Pixel handshake: pix_req is raised in REQ and held, together with stable
// pix_col/pix_row/pix_plane, until a clock edge in REQ sees pix_ack=1. That
// edge captures both rgb triples and drops pix_req. pix_ack is ignored in
// every other state, and may already be high on the first REQ cycle.
// -----------------------------------------------------------------------------
module led_panel_scan_ctrl #(
   parameter int COLS      = 32,
   parameter int PLANES    = 2,
   parameter int BASE_HOLD = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rowmax_in,
   output logic       pix_req,
   output logic [7:0] pix_col,
   output logic [3:0] pix_row,
   output logic [1:0] pix_plane,
   input  logic       pix_ack,
   input  logic [2:0] pix_lo_rgb,
   input  logic [2:0] pix_hi_rgb,
   output logic       red_out,
   output logic       green_out,
   output logic       blue_out,
   output logic       sclk_out,
   output logic       latch_out,
   output logic       blank_out,
   output logic       aclk_out,
   output logic       arst_out,
   output logic       frame_out,
   output logic [2:0] dbg_state_out
);

   typedef enum logic [2:0] {
      S_REQ      = 3'd0,
      S_SHIFT_LO = 3'd1,
      S_SHIFT_HI = 3'd2,
      S_LATCH    = 3'd3,
      S_HOLD     = 3'd4,
      S_NEXT     = 3'd5
   } state_t;

   localparam logic [7:0]  LAST_COL    = 8'(COLS - 1);
   localparam logic [1:0]  LAST_PLANE  = 2'(PLANES - 1);
   localparam logic [15:0] BASE_HOLD_W = 16'(BASE_HOLD);

   state_t      r_state;
   logic [7:0]  r_col;
   logic [3:0]  r_row;
   logic [1:0]  r_plane;
   logic [15:0] r_hold;
   logic [2:0]  r_hi_rgb;
   logic [2:0]  r_rgb;
   logic        r_pix_req;
   logic        r_sclk;
   logic        r_latch;
   logic        r_blank;
   logic        r_aclk;
   logic        r_arst;
   logic        r_frame;

   // Outputs are registered and written on the edge that enters a state, so
   // they describe the state currently held in r_state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_REQ;
         r_col     <= 8'd0;
         r_row     <= 4'd0;
         r_plane   <= 2'd0;
         r_hold    <= 16'd0;
         r_hi_rgb  <= 3'd0;
         r_rgb     <= 3'd0;
         r_pix_req <= 1'b0;
         r_sclk    <= 1'b0;
         r_latch   <= 1'b0;
         r_blank   <= 1'b1;
         r_aclk    <= 1'b0;
         r_arst    <= 1'b1;
         r_frame   <= 1'b0;
      end else begin
         // Single-cycle pulses default low; only the entering edge raises them.
         r_latch <= 1'b0;
         r_aclk  <= 1'b0;
         r_arst  <= 1'b0;
         r_frame <= 1'b0;

         case (r_state)
            S_REQ: begin
               if (pix_ack) begin
                  // Lower-half colour goes straight to the lane for SHIFT_LO;
                  // the upper half waits one cycle in r_hi_rgb.
                  r_rgb     <= pix_lo_rgb;
                  r_hi_rgb  <= pix_hi_rgb;
                  r_pix_req <= 1'b0;
                  r_sclk    <= 1'b0;
                  r_state   <= S_SHIFT_LO;
               end else begin
                  // Covers the first REQ cycle after reset, where pix_req is
                  // still at its reset value.
                  r_pix_req <= 1'b1;
               end
            end

            S_SHIFT_LO: begin
               r_sclk  <= 1'b1;
               r_rgb   <= r_hi_rgb;
               r_state <= S_SHIFT_HI;
            end

            S_SHIFT_HI: begin
               r_sclk <= 1'b0;
               if (r_col == LAST_COL) begin
                  r_col   <= 8'd0;
                  r_latch <= 1'b1;
                  r_state <= S_LATCH;
               end else begin
                  r_col     <= r_col + 8'd1;
                  r_pix_req <= 1'b1;
                  r_state   <= S_REQ;
               end
            end

            S_LATCH: begin
               // HOLD runs until the counter reaches zero, so load one less
               // than the on-time of this plane.
               r_hold  <= (BASE_HOLD_W << r_plane) - 16'd1;
               r_blank <= 1'b0;
               r_state <= S_HOLD;
            end

            S_HOLD: begin
               if (r_hold == 16'd0) begin
                  r_blank <= 1'b1;
                  r_state <= S_NEXT;
                  if (r_plane != LAST_PLANE) begin
                     r_plane <= r_plane + 2'd1;
                  end else begin
                     r_plane <= 2'd0;
                     // >= so a rowmax lowered below the current row still wraps.
                     if (r_row >= rowmax_in) begin
                        r_row   <= 4'd0;
                        r_arst  <= 1'b1;
                        r_frame <= 1'b1;
                     end else begin
                        r_row  <= r_row + 4'd1;
                        r_aclk <= 1'b1;
                     end
                  end
               end else begin
                  r_hold <= r_hold - 16'd1;
               end
            end

            S_NEXT: begin
               r_pix_req <= 1'b1;
               r_state   <= S_REQ;
            end

            default: begin
               r_pix_req <= 1'b0;
               r_sclk    <= 1'b0;
               r_blank   <= 1'b1;
               r_state   <= S_REQ;
            end
         endcase
      end
   end

   assign pix_req       = r_pix_req;
   assign pix_col       = r_col;
   assign pix_row       = r_row;
   assign pix_plane     = r_plane;
   assign red_out       = r_rgb[2];
   assign green_out     = r_rgb[1];
   assign blue_out      = r_rgb[0];
   assign sclk_out      = r_sclk;
   assign latch_out     = r_latch;
   assign blank_out     = r_blank;
   assign aclk_out      = r_aclk;
   assign arst_out      = r_arst;
   assign frame_out     = r_frame;
   assign dbg_state_out = r_state;

endmodule
